// File: rtl/lane_arbiter4_if.sv
// Handshake bundle between the four lane requesters and lane_arbiter4.
//   req         : per-lane request levels (bit i = lane i)
//   done        : current grantee releases the resource
//   sel         : registered index of the granted lane (decoder select)
//   gnt_valid   : a grant is active
//   gnt         : one-hot grant, zero while no grant is active
//   grant_count : number of grants issued, wraps at 2^CNT_W
//   timeout     : one-cycle pulse after a forced release
// Modports: master = requester side, slave = arbiter side.
interface lane_arbiter4_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       req;
  logic             done;
  logic [1:0]       sel;
  logic             gnt_valid;
  logic [3:0]       gnt;
  logic [CNT_W-1:0] grant_count;
  logic             timeout;

  modport master (
    output req, done,
    input  sel, gnt_valid, gnt, grant_count, timeout
  );

  modport slave (
    input  req, done,
    output sel, gnt_valid, gnt, grant_count, timeout
  );
endinterface

// File: rtl/lane_arbiter4.sv
// Round-robin arbiter sharing one resource among four lane requesters.
// Grants are exclusive and separated by one dead cycle (GAP) after each
// release. All outputs are registered.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_arb : lane_arbiter4_if.slave (req/done in; sel/gnt_valid/gnt/
//            grant_count/timeout out)
// Optional feature macro: ARB_TIMEOUT_EN -- forces a release after a grant
// has been held HOLD_MAX cycles and pulses timeout during the following GAP.
module lane_arbiter4 #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  lane_arbiter4_if.slave io_arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  if ((HOLD_MAX == 0) || (HOLD_MAX > 255)) begin : g_hold_max_range
    $error("lane_arbiter4: HOLD_MAX must be in 1..255");
  end

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_idx;
  logic             w_user_rel;
  logic             w_force_rel;

  // Round-robin search: first set request starting just after r_ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i + 1);
      if (!w_found && io_arb.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Voluntary release: explicit done or the owner withdrawing its request.
  assign w_user_rel = io_arb.done || !io_arb.req[r_sel];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = 8;

  logic [TMR_W-1:0] r_timer;

  // Counts completed grant cycles; restarts from zero on every new grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == GRANT) begin
      r_timer <= r_timer + TMR_W'(1);
    end else begin
      r_timer <= '0;
    end
  end

  // Fires on the edge that ends the HOLD_MAX-th visible grant cycle.
  assign w_force_rel = (r_state == GRANT) && (r_timer == TMR_W'(HOLD_MAX - 1));
`else
  assign w_force_rel = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_ptr_nxt       = r_ptr;
    w_gnt_valid_nxt = r_gnt_valid;
    w_gnt_nxt       = r_gnt;
    w_cnt_nxt       = r_cnt;
    w_timeout_nxt   = 1'b0;

    case (r_state)
      IDLE, GAP: begin
        if (w_found) begin
          w_state_nxt     = GRANT;
          w_sel_nxt       = w_win;
          w_gnt_valid_nxt = 1'b1;
          w_gnt_nxt       = 4'b0001 << w_win;
          w_cnt_nxt       = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt     = IDLE;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_nxt       = 4'b0000;
        end
      end
      GRANT: begin
        if (w_user_rel || w_force_rel) begin
          w_state_nxt     = GAP;
          w_ptr_nxt       = r_sel;
          w_gnt_valid_nxt = 1'b0;
          w_gnt_nxt       = 4'b0000;
          w_timeout_nxt   = w_force_rel && !w_user_rel;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_valid_nxt = 1'b0;
        w_gnt_nxt       = 4'b0000;
      end
    endcase
  end

  // State and output registers; ptr=3 gives lane 0 priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= 2'b00;
      r_ptr       <= 2'b11;
      r_gnt_valid <= 1'b0;
      r_gnt       <= 4'b0000;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt       <= w_gnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign io_arb.sel         = r_sel;
  assign io_arb.gnt_valid   = r_gnt_valid;
  assign io_arb.gnt         = r_gnt;
  assign io_arb.grant_count = r_cnt;
  assign io_arb.timeout     = r_timeout;

endmodule

// File: tb/tb_lane_arbiter4.sv
// Directed self-checking bench for lane_arbiter4 (HOLD_MAX=4, CNT_W=8).
// Builds with or without ARB_TIMEOUT_EN; the hold test adapts to the build.
module tb_lane_arbiter4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lane_arbiter4_if #(.CNT_W(8)) arb ();

  lane_arbiter4 #(
    .HOLD_MAX(4),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_arb(arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_gnt;
    n_checks = 0;
    n_fail   = 0;
    arb.req  = 4'b0000;
    arb.done = 1'b0;
    rst_n    = 1'b0;

    // Reset values
    #2;
    chk("rst_sel",   32'(arb.sel), 32'd0);
    chk("rst_valid", 32'(arb.gnt_valid), 32'd0);
    chk("rst_gnt",   32'(arb.gnt), 32'd0);
    chk("rst_count", 32'(arb.grant_count), 32'd0);
    chk("rst_tmo",   32'(arb.timeout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(arb.gnt_valid), 32'd0);

    // Single request on lane 2
    arb.req = 4'b0100;
    tick();
    chk("l2_sel",   32'(arb.sel), 32'd2);
    chk("l2_gnt",   32'(arb.gnt), 32'h4);
    chk("l2_valid", 32'(arb.gnt_valid), 32'd1);
    chk("l2_count", 32'(arb.grant_count), 32'd1);
    tick();
    chk("l2_hold", 32'(arb.gnt), 32'h4);

    // Asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt",   32'(arb.gnt), 32'd0);
    chk("arst_sel",   32'(arb.sel), 32'd0);
    chk("arst_valid", 32'(arb.gnt_valid), 32'd0);
    chk("arst_count", 32'(arb.grant_count), 32'd0);
    tick();
    rst_n   = 1'b1;
    arb.req = 4'b0000;
    tick();

    // All lanes requesting: order 0,1,2,3,0 with one dead cycle between
    arb.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      chk("rr_gnt",   32'(arb.gnt), 32'(exp_gnt));
      chk("rr_sel",   32'(arb.sel), 32'(k % 4));
      chk("rr_count", 32'(arb.grant_count), 32'(k + 1));
      tick();
      chk("rr_hold", 32'(arb.gnt), 32'(exp_gnt));
      arb.done = 1'b1;
      tick();
      arb.done = 1'b0;
      chk("rr_gap_gnt",   32'(arb.gnt), 32'd0);
      chk("rr_gap_valid", 32'(arb.gnt_valid), 32'd0);
      chk("rr_gap_sel",   32'(arb.sel), 32'(k % 4));
    end
    arb.req = 4'b0000;
    tick();
    chk("rr_to_idle", 32'(arb.gnt_valid), 32'd0);

    // Lane 1 withdraws while lane 3 waits
    arb.req = 4'b0010;
    tick();
    chk("wd_gnt1", 32'(arb.gnt), 32'h2);
    arb.req = 4'b1000;
    tick();
    chk("wd_gap", 32'(arb.gnt), 32'd0);
    tick();
    chk("wd_gnt3",  32'(arb.gnt), 32'h8);
    chk("wd_sel3",  32'(arb.sel), 32'd3);
    chk("wd_count", 32'(arb.grant_count), 32'd7);

    // done while idle is ignored
    arb.req = 4'b0000;
    tick();
    tick();
    arb.done = 1'b1;
    tick();
    tick();
    tick();
    chk("idone_valid", 32'(arb.gnt_valid), 32'd0);
    chk("idone_gnt",   32'(arb.gnt), 32'd0);
    chk("idone_count", 32'(arb.grant_count), 32'd7);
    chk("idone_sel",   32'(arb.sel), 32'd3);
    arb.done = 1'b0;

    // grant_count wraps after 256 grants
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    arb.req = 4'b0001;
    tick();
    chk("wrap_first", 32'(arb.grant_count), 32'd1);
    for (int i = 0; i < 254; i++) begin
      arb.done = 1'b1;
      tick();
      arb.done = 1'b0;
      tick();
    end
    chk("wrap_255", 32'(arb.grant_count), 32'd255);
    arb.done = 1'b1;
    tick();
    arb.done = 1'b0;
    tick();
    chk("wrap_0",   32'(arb.grant_count), 32'd0);
    chk("wrap_gnt", 32'(arb.gnt), 32'h1);

    // Two lanes requesting, no done
    rst_n   = 1'b0;
    arb.req = 4'b0000;
    tick();
    rst_n   = 1'b1;
    arb.req = 4'b0011;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int j = 0; j < 4; j++) begin
      chk("to_l0_gnt", 32'(arb.gnt), 32'h1);
      chk("to_l0_tmo", 32'(arb.timeout), 32'd0);
      if (j < 3) tick();
    end
    tick();
    chk("to_gap1_gnt", 32'(arb.gnt), 32'd0);
    chk("to_gap1_tmo", 32'(arb.timeout), 32'd1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("to_l1_gnt", 32'(arb.gnt), 32'h2);
      chk("to_l1_tmo", 32'(arb.timeout), 32'd0);
    end
    tick();
    chk("to_gap2_gnt", 32'(arb.gnt), 32'd0);
    chk("to_gap2_tmo", 32'(arb.timeout), 32'd1);
    tick();
    chk("to_back_l0", 32'(arb.gnt), 32'h1);
    chk("to_back_tmo", 32'(arb.timeout), 32'd0);
    chk("to_count",   32'(arb.grant_count), 32'd3);
`else
    for (int j = 0; j < 1000; j++) begin
      chk("hold_l0", 32'({arb.timeout, arb.gnt}), 32'({1'b0, 4'b0001}));
      tick();
    end
    chk("hold_count", 32'(arb.grant_count), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_arbiter4.md
Name: lane_arbiter4

Overview:
- Round-robin arbiter that shares one 4-way resource among 4 lane requesters (the four finger/key lanes), e.g. a shared note-judge or display slot.
- Produces a registered 2-bit lane index `sel` that drives the 2-to-4 decoder select input.
- Also produces a matching one-hot grant, a valid flag and a grant counter.
- Guarantees exactly one grantee and a one-cycle break-before-make gap between grants.

Parameters:
- HOLD_MAX, 16, maximum consecutive cycles one grant may be held (used only with ARB_TIMEOUT_EN); legal range 1..255.
- CNT_W, 8, width of the `grant_count` output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  per-lane request levels; bit i = lane i wants the resource.
- done  input  1  current grantee releases the resource (1-cycle pulse or level).
- sel  output  2  registered index of the granted lane; feeds the decoder select.
- gnt_valid  output  1  high while a grant is active.
- gnt  output  4  one-hot grant; equals decode(sel) when gnt_valid=1, else 4'b0000.
- grant_count  output  CNT_W  number of grants issued; wraps 2^CNT_W-1 -> 0.
- timeout  output  1  1-cycle pulse on a forced release.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, sel=2'b00, gnt_valid=0, gnt=0, grant_count=0, timeout=0, ptr=2'b11, timer=0. Lane 0 therefore has top priority after reset.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States:
  - IDLE: no grant.
  - GRANT: resource owned by lane `sel`.
  - GAP: 1-cycle dead time after a release.
- Arbitration (evaluated in IDLE and GAP): search req starting at ptr+1 mod 4, ascending with wrap (3 -> 0). Pick the first set bit as the winner w.
- IDLE: if req != 0 at edge N, then at N+1: state=GRANT, sel=w, gnt_valid=1, gnt=one-hot(w), grant_count+1. If req == 0, stay in IDLE.
- GRANT: hold sel/gnt stable. Release when done=1, or req[sel]=0 (requester withdraws), or a timeout fires (feature).
- On release at edge N: ptr<=sel; at N+1: state=GAP, gnt_valid=0, gnt=0.
- Requests from other lanes during GRANT are ignored until release.
- GAP: lasts exactly 1 cycle with gnt=0. It arbitrates on the current req and the updated ptr, then goes to GRANT (same rules as IDLE) or to IDLE. Back-to-back grants are therefore spaced 1 idle cycle apart: done at edge N, new gnt visible at N+2.
- sel retains the last granted index while gnt_valid=0; it is not cleared.
- done asserted in IDLE or GAP is ignored. done and req[sel]=0 together count as a single release.
- A req pulse shorter than one cycle between edges is not seen.
- grant_count increments only on entry to GRANT. It wraps silently.
- rst_n asserted mid-grant: outputs drop immediately (async). After reset deasserts, the first grant again starts from lane 0 priority.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - timer counts cycles with gnt_valid=1 and clears on entering GRANT.
  - When timer reaches HOLD_MAX with no other release, a forced release occurs.
  - timeout=1 for exactly the first GAP cycle; ptr advances past the evicted lane.
  - The evicted lane may be re-granted only after the other requesting lanes have had a turn.
  - Worst case, a grant lasts HOLD_MAX cycles.
- Not defined: no timer logic, timeout tied to 0, grants last indefinitely until done or withdraw.

Test Plan:
- Reset then req=4'b0100 at cycle 2 -> cycle 3: sel=2, gnt=4'b0100, gnt_valid=1, grant_count=1; async rst_n low mid-grant -> gnt=0 and sel=0 immediately.
- req=4'b1111 held, done pulsed once per grant -> grant order 0,1,2,3,0; each gnt high until done, then one gnt=0 cycle between grants.
- Lane 1 granted, req changes 4'b0010 -> 4'b1000 (withdraw) -> gnt=0 next cycle, then gnt=4'b1000 the cycle after, ptr=1.
- done asserted while IDLE with req=0 -> no state change, grant_count unchanged; 256 grants with CNT_W=8 -> grant_count reads 0.
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011, no done -> lane 0 holds 4 cycles, timeout=1 for 1 cycle, then lane 1 granted for 4 cycles, then lane 0.
- Without ARB_TIMEOUT_EN, same stimulus -> lane 0 held indefinitely (check 1000 cycles), timeout stays 0.
